vga_ball_animator: RTL
======================

// Module: vga_ball_animator
// PURPOSE
//   Frame-synchronous motion controller for the VGA ball peripheral. Once every FRAME_DIV
//   frames, at the start of vertical sync, computes the next ball position with wall bounce
//   and writes it into the peripheral's 8-bit register file over an Avalon-MM master write
//   port (addr 3 = ball_x, addr 4 = ball_y). Sits beside the HPS bridge; the peripheral is
//   shared at the interconnect.
// PARAMETERS
//   X_MIN      0    left bound, ball_x units (1 unit = 4 px)
//   X_MAX      95   right bound (160 cols - 64-unit ball - 1)
//   Y_MIN      0    top bound, ball_y units (1 unit = 4 lines)
//   Y_MAX      55   bottom bound (120 rows - 64-unit ball - 1)
//   X_INIT     3    ball_x after reset
//   Y_INIT     3    ball_y after reset
//   STEP_X     1    ball_x change per update, 1..15
//   STEP_Y     1    ball_y change per update, 1..15
//   FRAME_DIV  1    frames per update, 1..255
// PORTS
//   clk            in   1  system clock (50 MHz)
//   reset_n        in   1  asynchronous active-low reset
//   enable         in   1  1 = animate; 0 = finish current sequence, then hold
//   vga_vs         in   1  VGA_VS from the peripheral, active-low, same clock domain
//   m_address      out  3  register address
//   m_writedata    out  8  register data
//   m_write        out  1  write strobe
//   m_chipselect   out  1  equals m_write
//   m_waitrequest  in   1  interconnect stall
//   busy           out  1  high whenever the FSM is not in IDLE
//   overrun        out  1  sticky: vsync edge arrived while busy; cleared only by reset
// BEHAVIOUR
//   Reset (async assert, sync release): x=X_INIT, y=Y_INIT, dir_x=dir_y=+; frame_cnt=0;
//     FSM=IDLE; m_write=m_chipselect=0; m_address=0; m_writedata=0; busy=0; overrun=0.
//   vs_q register; vsync edge = vs_q & ~vga_vs (falling edge), one cycle wide.
//   IDLE: on edge with enable=1, frame_cnt++. When frame_cnt reaches FRAME_DIV-1 it clears
//     and the FSM enters CALC. Edge with enable=0: ignored, frame_cnt held.
//   CALC (1 cycle): both axes updated in parallel using 9-bit arithmetic.
//     dir +: if pos+STEP >= MAX then pos=MAX, dir=-, else pos+=STEP.
//     dir -: if pos <= MIN+STEP then pos=MIN, dir=+, else pos-=STEP.
//     bounce = either axis flipped this CALC.
//   WR_X: m_write=1, addr 3, data x. Signals held stable while m_waitrequest=1; advance on the
//     first cycle with m_waitrequest=0. Then WR_Y, same handshake (addr 4, data y), then IDLE.
//   Latency: first m_write asserts 2 cycles after the edge cycle; with no stalls the sequence
//     completes 4 cycles after the edge.
//   Edge while busy: discarded, overrun<=1, frame_cnt unchanged.
//   enable falling mid-sequence: current sequence completes; no new sequence starts.
//   Reset mid-write: m_write drops immediately (async); no partial-state retry.
// CONFIGURATION
//   VGA_BALL_ANIM_BG_CYCLE_EN defined: 3-bit pal_idx (reset 0) increments (wrapping 7->0)
//     on each CALC with bounce=1. After WR_Y the FSM writes WR_R, WR_G, WR_B
//     (addr 0,1,2, data = BG_PALETTE[pal_idx]) with the same handshake, then returns to IDLE.
//     With no bounce, behaviour is unchanged.
//   Macro undefined: pal_idx and the BG states are absent; addresses 0-2 are never written.
// STRUCTURE
//   vga_ball_pkg: ADDR_BG_R/G/B=3'd0/1/2, ADDR_BALL_X/Y=3'd3/4; anim_state_t enum
//     {IDLE,CALC,WR_X,WR_Y,WR_R,WR_G,WR_B}; BG_PALETTE[8] of 24-bit {r,g,b}, entry 0 = 24'h000080.
//   Sub-module ball_axis_stepper (MIN, MAX, INIT, STEP params; step strobe; pos, dir, flipped
//     outputs), instantiated once per axis. The FSM and write port stay in the top module.
// TESTING
//   1 Reset, enable=1, 1 vsync edge, waitrequest=0 -> writes (3,0x04) then (4,0x04); busy low
//     4 cycles after the edge.
//   2 Start x=94, dir +, STEP_X=1 -> next updates write x=95, then 94 (dir flipped).
//   3 waitrequest held high 5 cycles during WR_X -> addr/data/m_write stable throughout, exactly
//     one accepted write per register.
//   4 FRAME_DIV=3, 6 vsync edges -> exactly 2 write sequences, on the 3rd and 6th edges.
//   5 Vsync edge injected during WR_Y with stall -> overrun=1, no extra sequence; enable=0 ->
//     no writes on later edges.
//   6 BG_CYCLE_EN, y bounce at Y_MAX -> writes addr 3,4,0,1,2 with BG_PALETTE[1] bytes.

Source files
------------

// File: rtl/vga_ball_pkg.sv
// Shared constants for the VGA ball animator: register map, FSM state encoding
// and the background palette used when VGA_BALL_ANIM_BG_CYCLE_EN is defined.
package vga_ball_pkg;

  localparam logic [2:0] ADDR_BG_R   = 3'd0;
  localparam logic [2:0] ADDR_BG_G   = 3'd1;
  localparam logic [2:0] ADDR_BG_B   = 3'd2;
  localparam logic [2:0] ADDR_BALL_X = 3'd3;
  localparam logic [2:0] ADDR_BALL_Y = 3'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    WR_X = 3'd2,
    WR_Y = 3'd3,
    WR_R = 3'd4,
    WR_G = 3'd5,
    WR_B = 3'd6
  } anim_state_t;

  // {r,g,b} per entry; entry 0 matches the peripheral's power-up background
  localparam logic [23:0] BG_PALETTE [8] = '{
    24'h000080, 24'h800000, 24'h008000, 24'h808000,
    24'h800080, 24'h008080, 24'h404040, 24'hC0C0C0
  };

endpackage

// File: rtl/ball_axis_stepper.sv
// One axis of ball motion: position and direction registers with wall bounce.
// pos_next/flipped show the result the next step strobe will commit.
module ball_axis_stepper #(
  parameter int MIN  = 0,
  parameter int MAX  = 95,
  parameter int INIT = 3,
  parameter int STEP = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  output logic [7:0] pos,
  output logic [7:0] pos_next,
  output logic       dir,
  output logic       flipped
);

  logic [8:0] pos_ext_s;
  logic [8:0] sum_s;
  logic [8:0] diff_s;

  // Next position with clamp-and-reverse at either wall, 9-bit to avoid wrap
  always_comb begin
    pos_ext_s = {1'b0, pos};
    sum_s     = pos_ext_s + 9'(STEP);
    diff_s    = pos_ext_s - 9'(STEP);
    pos_next  = pos;
    flipped   = 1'b0;
    if (dir == 1'b0) begin
      if (sum_s >= 9'(MAX)) begin
        pos_next = 8'(MAX);
        flipped  = 1'b1;
      end else begin
        pos_next = sum_s[7:0];
      end
    end else begin
      if (pos_ext_s <= 9'(MIN) + 9'(STEP)) begin
        pos_next = 8'(MIN);
        flipped  = 1'b1;
      end else begin
        pos_next = diff_s[7:0];
      end
    end
  end

  // Commit the step; dir 0 = increasing, 1 = decreasing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos <= 8'(INIT);
      dir <= 1'b0;
    end else if (step) begin
      pos <= pos_next;
      dir <= dir ^ flipped;
    end else begin
      pos <= pos;
      dir <= dir;
    end
  end

endmodule

// File: rtl/vga_ball_animator.sv
// Frame-synchronous ball motion controller writing ball_x/ball_y over Avalon-MM.
// Define VGA_BALL_ANIM_BG_CYCLE_EN to also cycle the background colour on each bounce.
module vga_ball_animator
  import vga_ball_pkg::*;
#(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 95,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 55,
  parameter int X_INIT    = 3,
  parameter int Y_INIT    = 3,
  parameter int STEP_X    = 1,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       vga_vs,
  output logic [2:0] m_address,
  output logic [7:0] m_writedata,
  output logic       m_write,
  output logic       m_chipselect,
  input  logic       m_waitrequest,
  output logic       busy,
  output logic       overrun
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAME_DIV - 1);

  anim_state_t state_r;
  logic        vs_q_r;
  logic        vsync_edge_s;
  logic        step_s;
  logic [7:0]  frame_cnt_r;
  logic [7:0]  x_pos_s, x_next_s, y_pos_s, y_next_s;
  logic        x_dir_s, y_dir_s, x_flip_s, y_flip_s;
  logic        unused_s;
`ifdef VGA_BALL_ANIM_BG_CYCLE_EN
  logic [2:0]  pal_idx_r;
  logic        bounce_r;
`endif

  assign vsync_edge_s = vs_q_r & ~vga_vs;
  assign step_s       = (state_r == CALC);
  // x is written straight from the CALC result; y is read back after it settles
  assign unused_s     = ^{x_pos_s, y_next_s, x_dir_s, y_dir_s, x_flip_s, y_flip_s};

  ball_axis_stepper #(.MIN(X_MIN), .MAX(X_MAX), .INIT(X_INIT), .STEP(STEP_X)) u_axis_x (
    .clk(clk), .reset_n(reset_n), .step(step_s),
    .pos(x_pos_s), .pos_next(x_next_s), .dir(x_dir_s), .flipped(x_flip_s)
  );

  ball_axis_stepper #(.MIN(Y_MIN), .MAX(Y_MAX), .INIT(Y_INIT), .STEP(STEP_Y)) u_axis_y (
    .clk(clk), .reset_n(reset_n), .step(step_s),
    .pos(y_pos_s), .pos_next(y_next_s), .dir(y_dir_s), .flipped(y_flip_s)
  );

  // Sequencer FSM with registered bus outputs and sticky overrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      vs_q_r       <= 1'b0;
      frame_cnt_r  <= 8'd0;
      m_write      <= 1'b0;
      m_chipselect <= 1'b0;
      m_address    <= 3'd0;
      m_writedata  <= 8'd0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
`ifdef VGA_BALL_ANIM_BG_CYCLE_EN
      pal_idx_r    <= 3'd0;
      bounce_r     <= 1'b0;
`endif
    end else begin
      vs_q_r <= vga_vs;
      if (vsync_edge_s && busy) begin
        overrun <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (vsync_edge_s && enable) begin
            if (frame_cnt_r == FRAME_LAST) begin
              frame_cnt_r <= 8'd0;
              state_r     <= CALC;
              busy        <= 1'b1;
            end else begin
              frame_cnt_r <= frame_cnt_r + 8'd1;
            end
          end
        end
        CALC: begin
          state_r      <= WR_X;
          m_write      <= 1'b1;
          m_chipselect <= 1'b1;
          m_address    <= ADDR_BALL_X;
          m_writedata  <= x_next_s;
`ifdef VGA_BALL_ANIM_BG_CYCLE_EN
          bounce_r     <= x_flip_s | y_flip_s;
          if (x_flip_s || y_flip_s) begin
            pal_idx_r <= pal_idx_r + 3'd1;
          end
`endif
        end
        WR_X: begin
          if (!m_waitrequest) begin
            state_r     <= WR_Y;
            m_address   <= ADDR_BALL_Y;
            m_writedata <= y_pos_s;
          end
        end
        WR_Y: begin
          if (!m_waitrequest) begin
`ifdef VGA_BALL_ANIM_BG_CYCLE_EN
            if (bounce_r) begin
              state_r     <= WR_R;
              m_address   <= ADDR_BG_R;
              m_writedata <= BG_PALETTE[pal_idx_r][23:16];
            end else begin
              state_r      <= IDLE;
              m_write      <= 1'b0;
              m_chipselect <= 1'b0;
              busy         <= 1'b0;
            end
`else
            state_r      <= IDLE;
            m_write      <= 1'b0;
            m_chipselect <= 1'b0;
            busy         <= 1'b0;
`endif
          end
        end
`ifdef VGA_BALL_ANIM_BG_CYCLE_EN
        WR_R: begin
          if (!m_waitrequest) begin
            state_r     <= WR_G;
            m_address   <= ADDR_BG_G;
            m_writedata <= BG_PALETTE[pal_idx_r][15:8];
          end
        end
        WR_G: begin
          if (!m_waitrequest) begin
            state_r     <= WR_B;
            m_address   <= ADDR_BG_B;
            m_writedata <= BG_PALETTE[pal_idx_r][7:0];
          end
        end
        WR_B: begin
          if (!m_waitrequest) begin
            state_r      <= IDLE;
            m_write      <= 1'b0;
            m_chipselect <= 1'b0;
            busy         <= 1'b0;
          end
        end
`endif
        default: begin
          state_r      <= IDLE;
          m_write      <= 1'b0;
          m_chipselect <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
